// File: rtl/cle_pkg.sv
// Shared constants and FSM state type for the CLE pixel fetch front end.
package cle_pkg;

  localparam int IMG_W     = 32;
  localparam int IMG_H     = 32;
  localparam int ROM_DEPTH = 128;
  localparam int PIX_CNT_W = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } cle_fetch_state_t;

endpackage

// File: rtl/cle_byte_unpacker.sv
// Current-byte shift register plus one-byte prefetch slot.
// Emits one pixel per transfer; refills from the slot without a bubble.
module cle_byte_unpacker #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cap,
  input  logic [7:0] data,
  input  logic       xfer,
  input  logic       last_in_byte,
  output logic       pix_bit,
  output logic       cur_full,
  output logic       slot_full
);

  logic [7:0] sh;
  logic [7:0] slot;
  logic       cur_free;

  assign cur_free = !cur_full || (xfer && last_in_byte);
  assign pix_bit  = MSB_FIRST ? sh[7] : sh[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sh        <= '0;
      slot      <= '0;
      cur_full  <= 1'b0;
      slot_full <= 1'b0;
    end else if (cur_free) begin
      // data arriving while the current byte is free bypasses the slot
      if (slot_full) begin
        sh        <= slot;
        cur_full  <= 1'b1;
        slot_full <= 1'b0;
      end else if (cap) begin
        sh       <= data;
        cur_full <= 1'b1;
      end else begin
        sh       <= '0;
        cur_full <= 1'b0;
      end
    end else begin
      if (xfer) begin
        sh <= MSB_FIRST ? {sh[6:0], 1'b0} : {1'b0, sh[7:1]};
      end
      if (cap) begin
        slot      <= data;
        slot_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cle_pixel_fetch.sv
// CLE front end: scans the 128x8 image ROM and streams pixels
// in raster order with (x, y) tags over a valid/ready handshake.
module cle_pixel_fetch
  import cle_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int ROM_AW    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [7:0]        rom_q,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_bit,
  output logic [4:0]        pix_x,
  output logic [4:0]        pix_y,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ROM_AW-1:0] A_LAST =
    ROM_AW'(ROM_DEPTH - 1);
  localparam logic [PIX_CNT_W-1:0] C_LAST =
    PIX_CNT_W'(IMG_W * IMG_H - 1);

  cle_fetch_state_t     state;
  logic [PIX_CNT_W-1:0] cnt;
  logic                 inflight;
  logic                 exhausted;
  logic                 cur_full;
  logic                 slot_full;
  logic                 xfer;
  logic                 issue;

  assign pix_valid = (state == S_STREAM) && cur_full;
  assign xfer      = pix_valid && pix_ready;
  assign issue     = (state == S_STREAM) && !slot_full
                     && !inflight && !exhausted;
  assign pix_x     = cnt[4:0];
  assign pix_y     = cnt[9:5];
  assign pix_last  = (cnt == C_LAST);

  cle_byte_unpacker #(
    .MSB_FIRST(MSB_FIRST)
  ) u_unpack (
    .clk         (clk),
    .reset       (reset),
    .cap         (inflight),
    .data        (rom_q),
    .xfer        (xfer),
    .last_in_byte(&cnt[2:0]),
    .pix_bit     (pix_bit),
    .cur_full    (cur_full),
    .slot_full   (slot_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rom_a     <= '0;
      cnt       <= '0;
      inflight  <= 1'b0;
      exhausted <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer) cnt <= cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          rom_a     <= '0;
          exhausted <= 1'b0;
          if (start) begin
            state <= S_PRIME;
            busy  <= 1'b1;
          end
        end
        S_PRIME: begin
          // first cycle lets the ROM sample address 0
          if (!inflight) begin
            inflight <= 1'b1;
          end else begin
            inflight <= 1'b0;
            rom_a    <= ROM_AW'(1);
            state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          inflight <= issue;
          if (issue) begin
            if (rom_a == A_LAST) exhausted <= 1'b1;
            else                 rom_a     <= rom_a + 1'b1;
          end
          if (xfer && cnt == C_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          rom_a     <= '0;
          exhausted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cle_pixel_fetch.sv
// Directed bench for cle_pixel_fetch: MSB-first and LSB-first
// instances share one image ROM and one handshake.
module tb_cle_pixel_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pix_ready;
  logic [7:0] mem [128];

  logic [6:0] rom_a, rom_a0;
  logic [7:0] rom_q, rom_q0;
  logic       pix_valid, pix_valid0;
  logic       pix_bit, pix_bit0;
  logic [4:0] pix_x, pix_x0, pix_y, pix_y0;
  logic       pix_last, pix_last0;
  logic       busy, busy0, done, done0;

  int total = 0;
  int bad   = 0;

  int         beats, done_cnt, done_cyc, first_v;
  logic [7:0] row_m, row_l;
  logic       b8;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q  <= mem[rom_a];
    rom_q0 <= mem[rom_a0];
  end

  cle_pixel_fetch #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_a(rom_a), .rom_q(rom_q),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_bit(pix_bit), .pix_x(pix_x), .pix_y(pix_y),
    .pix_last(pix_last), .busy(busy), .done(done)
  );

  cle_pixel_fetch #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .rom_a(rom_a0), .rom_q(rom_q0),
    .pix_valid(pix_valid0), .pix_ready(pix_ready),
    .pix_bit(pix_bit0), .pix_x(pix_x0), .pix_y(pix_y0),
    .pix_last(pix_last0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gold(input int n, input bit msb);
    int k = n >> 3;
    int j = n & 7;
    logic [7:0] b = mem[k];
    return msb ? b[7-j] : b[j];
  endfunction

  // mode 0: ready high, 1: random ready, 2: stall 20 cycles at beat 7
  task automatic scan(input int mode, input int restart_at,
                      input int abort_at);
    int n = 0;
    int cyc = 0;
    int stall = 0;
    bit rs = 0;
    bit fin = 0;
    bit aborted = 0;
    done_cnt = 0; done_cyc = -1; first_v = -1;
    row_m = '0; row_l = '0; b8 = 1'b0;
    pix_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 4000 && !fin) begin
      if (abort_at >= 0 && n == abort_at) begin
        reset = 1'b1;
        aborted = 1;
        break;
      end
      case (mode)
        1: pix_ready = 1'($urandom_range(0, 1));
        2: if (n == 7 && stall < 20) begin
             pix_ready = 1'b0;
             stall++;
           end else pix_ready = 1'b1;
        default: pix_ready = 1'b1;
      endcase
      if (restart_at >= 0 && n == restart_at && !rs) begin
        start = 1'b1;
        rs = 1;
      end else start = 1'b0;
      if (n < 1024) chk("busy", busy, 1);
      if (mode != 1 && first_v >= 0 && n < 1024)
        chk("bubble", pix_valid, 1);
      if (pix_valid) begin
        if (first_v < 0) first_v = cyc;
        chk("beat_msb", {pix_bit, pix_x, pix_y, pix_last},
            {gold(n, 1), n[4:0], n[9:5], n == 1023});
        chk("beat_lsb", {pix_bit0, pix_x0, pix_y0, pix_last0},
            {gold(n, 0), n[4:0], n[9:5], n == 1023});
        if (n < 8) begin
          row_m[n] = pix_bit;
          row_l[n] = pix_bit0;
        end
        if (n == 8) b8 = pix_bit;
        if (pix_ready) n++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        if (n == 1024) fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    beats = n;
    if (!aborted) begin
      chk("timeout", 32'(fin), 1);
      repeat (3) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      chk("idle_rom_a", rom_a, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_msb", {rom_a, pix_valid, pix_bit, pix_x, pix_y,
                      pix_last, busy, done}, 0);
    chk("reset_lsb", {rom_a0, pix_valid0, pix_bit0, pix_x0, pix_y0,
                      pix_last0, busy0, done0}, 0);
    start = 1'b1;
    @(negedge clk);
    chk("reset_beats_start", busy, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", busy, 0);

    scan(0, -1, -1);
    chk("zero_beats", beats, 1024);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_done_cyc", done_cyc, 1027);
    chk("zero_first_valid", first_v, 3);

    mem[0] = 8'h81;
    scan(0, -1, -1);
    chk("x81_row_msb", row_m, 8'h81);
    chk("x81_row_lsb", row_l, 8'h81);

    mem[0] = 8'h80;
    scan(0, -1, -1);
    chk("x80_row_msb", row_m, 8'h01);
    chk("x80_row_lsb", row_l, 8'h80);

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    scan(1, -1, -1);
    chk("rand_beats", beats, 1024);
    chk("rand_done_cnt", done_cnt, 1);

    scan(0, 100, -1);
    chk("restart_beats", beats, 1024);
    chk("restart_done_cnt", done_cnt, 1);
    chk("restart_done_cyc", done_cyc, 1027);

    scan(0, -1, 300);
    chk("abort_no_done", done_cnt, 0);
    @(negedge clk);
    chk("abort_reset_msb", {rom_a, pix_valid, pix_bit, pix_x, pix_y,
                            pix_last, busy, done}, 0);
    reset = 1'b0;
    scan(0, -1, -1);
    chk("after_abort_beats", beats, 1024);
    chk("after_abort_done_cyc", done_cyc, 1027);

    mem[1] = 8'h80;
    scan(2, -1, -1);
    chk("stall_beat8_bit", b8, 1);
    chk("stall_beats", beats, 1024);
    chk("stall_done_cyc", done_cyc, 1047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cle_pixel_fetch.md
# cle_pixel_fetch

Front-end sequencer for the component labeling engine (CLE). Reads the 32x32 binary image from the 128x8 synchronous ROM and unpacks each byte into single pixels in raster order. Delivers the pixels to the labeling core over a valid/ready stream tagged with (x, y) coordinates. Owns the ROM address port outright, so the labeling core never drives `rom_a`.

## Interface
Parameters:
- `MSB_FIRST`, default 1: 1 means byte bit 7 is the leftmost pixel of its 8-pixel group; 0 means bit 0 is.
- `ROM_AW`, default 7: ROM address width. Fixed at 7 for the 128-byte image.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin an image scan. Sampled only in IDLE.
- `rom_a`, out, 7: ROM address. Registered.
- `rom_q`, in, 8: ROM data. Valid the cycle after the ROM samples `rom_a`.
- `pix_valid`, out, 1: pixel beat available.
- `pix_ready`, in, 1: consumer accepts the beat.
- `pix_bit`, out, 1: pixel value (1 = object).
- `pix_x`, out, 5: column, 0..31.
- `pix_y`, out, 5: row, 0..31.
- `pix_last`, out, 1: high on the pixel at (31,31).
- `busy`, out, 1: high from start acceptance until `done`.
- `done`, out, 1: one-cycle pulse after the last beat transfers.

## Operation
- Image map: byte k covers pixels 8k..8k+7.
  - Row y = k>>2.
  - Column base = (k&3)*8.
  - Within the byte, bit order is set by `MSB_FIRST`.
- FSM states: IDLE, PRIME, STREAM, DONE.
  - IDLE: `rom_a`=0. `start`=1 → PRIME, and `busy` goes high.
  - PRIME: wait for byte 0 to return. Load it into the shift register, advance `rom_a` to 1, then → STREAM.
  - STREAM: a beat transfers when `pix_valid & pix_ready` at a rising edge. After the transfer at (31,31) → DONE.
  - DONE: `done`=1 for one cycle, `busy` goes low, → IDLE.
- Buffering: one 8-bit shift register (current byte) plus one 8-bit prefetch slot.
  - A fetch is issued whenever the prefetch slot is empty and `rom_a` has not passed 127.
  - Returned data is captured two edges after `rom_a` is updated: one edge for the ROM to sample, one to capture.
  - When the 8th pixel of a byte transfers and the prefetch slot is full, the slot moves into the shift register on the same edge. This gives no bubble.
  - If the prefetch slot is empty at that point, `pix_valid` drops until the slot is filled.
- Coordinates come from a 10-bit pixel counter, with `pix_x` = cnt[4:0] and `pix_y` = cnt[9:5]. The counter increments only on a transfer.
- `rom_a` saturates at 127. No fetch beyond byte 127 is issued.
- `start` outside IDLE is ignored, with no restart.
- Backpressure: while `pix_valid`=1 and `pix_ready`=0, `pix_bit`, `pix_x`, `pix_y` and `pix_last` hold stable.
- `pix_valid` never deasserts without a transfer once asserted, except through `reset`.

## Timing
- Reset values:
  - `rom_a`=0
  - `pix_valid`=0, `pix_bit`=0, `pix_x`=0, `pix_y`=0, `pix_last`=0
  - `busy`=0, `done`=0
  - FSM=IDLE, both buffers empty.
- Start latency: `start` sampled at edge E0. ROM samples address 0 at E1 and byte 0 is captured at E2. `pix_valid` is first high in the cycle after E2.
- Throughput: 1 pixel/cycle with `pix_ready` held high. A full image takes 1024 transfer cycles plus 2 prime cycles plus 1 DONE cycle.
- `done` is high in the cycle after the edge where the (31,31) beat transfers. `busy` falls together with `done`.
- `reset` mid-scan: all state returns to reset values on the next edge. No `done` is issued and any partial byte is discarded.
- `reset` and `start` high on the same edge: `reset` wins.

## Structure
- Shared package `cle_pkg` holds:
  - `IMG_W`=32, `IMG_H`=32, `ROM_DEPTH`=128, `PIX_CNT_W`=10.
  - The FSM state enum `cle_fetch_state_t`.
- Sub-module `cle_byte_unpacker` contains the shift register, the prefetch slot, the bit-select by `MSB_FIRST`, and the slot-full/empty flags. The top level keeps the FSM, the ROM address counter and the pixel counter.

## Test plan
- ROM all 0x00, `pix_ready`=1:
  - Exactly 1024 beats with `pix_bit`=0.
  - `pix_last` only at (31,31).
  - `done` pulses exactly once, 1027 cycles after `start`.
- ROM byte 0 = 0x81, rest 0:
  - With `MSB_FIRST`=1, `pix_bit`=1 at x=0 and x=7 of y=0, zero elsewhere.
  - With `MSB_FIRST`=0, the result is the same (symmetric pattern).
  - Byte 0 = 0x80 gives x=0 only with `MSB_FIRST`=1, and x=7 only with `MSB_FIRST`=0.
- Random `pix_ready` (50%):
  - Beat outputs are stable during stalls.
  - The beat sequence equals the golden unpack of the ROM, with no drops or duplicates.
  - `rom_a` never exceeds 127.
- `start` pulsed again during STREAM: no effect, and the beat count is still 1024.
- `reset` asserted at beat 300, then a fresh `start`:
  - Outputs return to reset values the next cycle.
  - No `done` is issued before the reset.
  - The new scan begins at (0,0) with byte 0 data.
- Byte boundary with `pix_ready` low for 20 cycles at beat 7: after release, beat 8 carries byte 1, bit 7 (`MSB_FIRST`=1), and no `pix_valid` bubble is seen.
